butterfly_tf: RTL and testbench

Radix-2 decimation-in-time butterfly for the FFT datapath: accepts a complex pair (x, y) and a twiddle index, and returns (x + W·y)/2 and (x − W·y)/2. The block is the requesting side of the `twiddlefactors` lookup interface. It drives the lookup's address and address-strobe inputs and consumes its registered 24-bit twiddle word one cycle later. It sits between the FFT stage address generator and the stage output buffer, and is fully pipelined at one sample per cycle with no backpressure.

---
 rtl/fft_pkg.sv | 41 ++++
 rtl/butterfly_tf_cmult_pipe.sv | 79 +++++++
 rtl/butterfly_tf.sv | 178 +++++++++++++++++
 tb/tb_butterfly_tf.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared constants and helpers for the FFT datapath stages.
//   X_WDTH_DEF / TF_WDTH_DEF : default data / twiddle component widths.
//   TF_ADDR_WDTH_DEF         : default twiddle index width (16 twiddles).
//   M_WDTH_DEF               : default sideband message width.
//   tf_shift()               : Q-format shift for a twiddle width (1.0 = 2^(w-2)).
//   saturate()               : clamps a signed value to a w-bit signed range.
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int X_WDTH_DEF       = 12;
    localparam int TF_WDTH_DEF      = 12;
    localparam int TF_ADDR_WDTH_DEF = 4;
    localparam int M_WDTH_DEF       = 1;

    // Wide signed carrier used when a value is handed to the saturation helper.
    typedef logic signed [31:0] wide_t;

    // Twiddles are Q(w-2): one sign bit, one integer bit, w-2 fraction bits.
    function automatic int tf_shift(input int tf_wdth);
        return tf_wdth - 2;
    endfunction

    // Clamp v to [-2^(w-1), 2^(w-1)-1]. Callers detect saturation by comparing
    // the result against the original value.
    function automatic wide_t saturate(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/butterfly_tf_cmult_pipe.sv
// -----------------------------------------------------------------------------
// cmult_pipe
// Two-stage pipelined complex multiply z = W * y with Q-format rescale.
//   clk    : clock, rising edge.
//   y_in   : {re, im} signed data, X_WDTH bits per component.
//   w_in   : {re, im} signed twiddle, TF_WDTH bits per component, Q(TF_WDTH-2).
//   z_out  : {re, im} signed product, X_WDTH+1 bits per component, valid two
//            clock edges after y_in/w_in are presented.
// Stage A registers the four full-width partial products; stage B registers
// the rescaled sums. No reset: validity is tracked by the caller.
// -----------------------------------------------------------------------------
module cmult_pipe
    import fft_pkg::*;
#(
    parameter int X_WDTH  = X_WDTH_DEF,
    parameter int TF_WDTH = TF_WDTH_DEF
) (
    input  logic                      clk,
    input  logic [2*X_WDTH-1:0]       y_in,
    input  logic [2*TF_WDTH-1:0]      w_in,
    output logic [2*(X_WDTH+1)-1:0]   z_out
);

    localparam int P_WDTH = X_WDTH + TF_WDTH;   // full product width
    localparam int S_WDTH = P_WDTH + 1;         // sum of two products
    localparam int Z_WDTH = X_WDTH + 1;         // rescaled result, |W| <= 1
    localparam int SHIFT  = tf_shift(TF_WDTH);

    logic signed [X_WDTH-1:0]  y_re;
    logic signed [X_WDTH-1:0]  y_im;
    logic signed [TF_WDTH-1:0] w_re;
    logic signed [TF_WDTH-1:0] w_im;

    assign y_re = y_in[2*X_WDTH-1:X_WDTH];
    assign y_im = y_in[X_WDTH-1:0];
    assign w_re = w_in[2*TF_WDTH-1:TF_WDTH];
    assign w_im = w_in[TF_WDTH-1:0];

    // Product slots: 0 = yr*wr, 1 = yi*wi, 2 = yr*wi, 3 = yi*wr.
    logic signed [P_WDTH-1:0] prod_d [4];
    logic signed [P_WDTH-1:0] prod_q [4];

    always_comb begin
        prod_d[0] = P_WDTH'(y_re) * P_WDTH'(w_re);
        prod_d[1] = P_WDTH'(y_im) * P_WDTH'(w_im);
        prod_d[2] = P_WDTH'(y_re) * P_WDTH'(w_im);
        prod_d[3] = P_WDTH'(y_im) * P_WDTH'(w_re);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_prod
            always_ff @(posedge clk) begin
                prod_q[gi] <= prod_d[gi];
            end
        end
    endgenerate

    logic signed [Z_WDTH-1:0] z_re_d;
    logic signed [Z_WDTH-1:0] z_im_d;
    logic signed [Z_WDTH-1:0] z_re_q;
    logic signed [Z_WDTH-1:0] z_im_q;

    // Sum at one extra bit, then drop the Q fraction with a flooring shift.
    // The narrowing cast keeps the low Z_WDTH bits, which hold the whole
    // value because the twiddle magnitude never exceeds one.
    always_comb begin
        z_re_d = Z_WDTH'((S_WDTH'(prod_q[0]) - S_WDTH'(prod_q[1])) >>> SHIFT);
        z_im_d = Z_WDTH'((S_WDTH'(prod_q[2]) + S_WDTH'(prod_q[3])) >>> SHIFT);
    end

    always_ff @(posedge clk) begin
        z_re_q <= z_re_d;
        z_im_q <= z_im_d;
    end

    assign z_out = {z_re_q, z_im_q};

endmodule

// File: rtl/butterfly_tf.sv
// -----------------------------------------------------------------------------
// butterfly_tf
// Radix-2 DIT butterfly: out_x = (x + W*y)/2, out_y = (x - W*y)/2, with
// per-component saturation. Requests W from an external registered twiddle
// lookup and consumes its answer one cycle later. Latency 4, one sample/cycle.
//   clk, rst      : clock and synchronous active-high reset.
//   in_nd         : input sample valid.
//   in_addr       : twiddle index for this sample.
//   in_x, in_y    : complex {re, im} inputs, signed.
//   in_m          : sideband message, delayed unchanged to out_m.
//   tf_addr       : twiddle lookup address (= in_addr).
//   tf_addr_nd    : twiddle lookup strobe (= in_nd while not in reset).
//   tf_in         : twiddle {re, im} from the lookup, one cycle after strobe.
//   out_nd        : output valid.
//   out_x, out_y  : butterfly results {re, im}; hold while out_nd is low.
//   out_m         : message belonging to the current output.
//   out_ovf       : a component of this output saturated.
// -----------------------------------------------------------------------------
module butterfly_tf
    import fft_pkg::*;
#(
    parameter int X_WDTH       = X_WDTH_DEF,
    parameter int TF_WDTH      = TF_WDTH_DEF,
    parameter int TF_ADDR_WDTH = TF_ADDR_WDTH_DEF,
    parameter int M_WDTH       = M_WDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_nd,
    input  logic [TF_ADDR_WDTH-1:0] in_addr,
    input  logic [2*X_WDTH-1:0]     in_x,
    input  logic [2*X_WDTH-1:0]     in_y,
    input  logic [M_WDTH-1:0]       in_m,
    output logic [TF_ADDR_WDTH-1:0] tf_addr,
    output logic                    tf_addr_nd,
    input  logic [2*TF_WDTH-1:0]    tf_in,
    output logic                    out_nd,
    output logic [2*X_WDTH-1:0]     out_x,
    output logic [2*X_WDTH-1:0]     out_y,
    output logic [M_WDTH-1:0]       out_m,
    output logic                    out_ovf
);

    localparam int Z_WDTH = X_WDTH + 1;

    // The lookup is addressed in the same cycle the sample arrives.
    assign tf_addr    = in_addr;
    assign tf_addr_nd = in_nd & ~rst;

    // ---------------- delay line: valid, x, m ----------------
    logic                v1_d, v2_d, v3_d, v4_d;
    logic                v1_q, v2_q, v3_q, v4_q;
    logic [2*X_WDTH-1:0] x1_d, x2_d, x3_d;
    logic [2*X_WDTH-1:0] x1_q, x2_q, x3_q;
    logic [2*X_WDTH-1:0] y1_d, y1_q;
    logic [M_WDTH-1:0]   m1_d, m2_d, m3_d;
    logic [M_WDTH-1:0]   m1_q, m2_q, m3_q;

    // ---------------- output registers ----------------
    logic [2*X_WDTH-1:0] out_x_d, out_x_q;
    logic [2*X_WDTH-1:0] out_y_d, out_y_q;
    logic [M_WDTH-1:0]   out_m_d, out_m_q;
    logic                out_ovf_d, out_ovf_q;

    // ---------------- stages 2-3: z = W * y ----------------
    logic [2*Z_WDTH-1:0] z_q;

    cmult_pipe #(
        .X_WDTH  (X_WDTH),
        .TF_WDTH (TF_WDTH)
    ) u_cmult (
        .clk   (clk),
        .y_in  (y1_q),
        .w_in  (tf_in),
        .z_out (z_q)
    );

    // ---------------- stage 4: add/sub, halve, saturate ----------------
    // Component 0 is the imaginary (lower) half, component 1 the real half.
    logic [X_WDTH-1:0] sum_c  [2];
    logic [X_WDTH-1:0] diff_c [2];
    logic [1:0]        ovf_c;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_comp
            logic signed [X_WDTH-1:0] x_c;
            logic signed [Z_WDTH-1:0] z_c;
            logic signed [X_WDTH+1:0] half_sum;
            logic signed [X_WDTH+1:0] half_diff;
            wide_t                    sum_sat;
            wide_t                    diff_sat;

            // X_WDTH+2 bits holds x +/- z without wrap; the shift floors.
            always_comb begin
                x_c       = x3_q[gi*X_WDTH +: X_WDTH];
                z_c       = z_q[gi*Z_WDTH +: Z_WDTH];
                half_sum  = ((X_WDTH+2)'(x_c) + (X_WDTH+2)'(z_c)) >>> 1;
                half_diff = ((X_WDTH+2)'(x_c) - (X_WDTH+2)'(z_c)) >>> 1;
                sum_sat   = saturate(wide_t'(half_sum), X_WDTH);
                diff_sat  = saturate(wide_t'(half_diff), X_WDTH);
            end

            assign sum_c[gi]  = sum_sat[X_WDTH-1:0];
            assign diff_c[gi] = diff_sat[X_WDTH-1:0];
            assign ovf_c[gi]  = (sum_sat != wide_t'(half_sum)) |
                                (diff_sat != wide_t'(half_diff));
        end
    endgenerate

    // ---------------- next-state ----------------
    always_comb begin
        v1_d = in_nd;
        v2_d = v1_q;
        v3_d = v2_q;
        v4_d = v3_q;

        x1_d = in_x;
        y1_d = in_y;
        m1_d = in_m;
        x2_d = x1_q;
        m2_d = m1_q;
        x3_d = x2_q;
        m3_d = m2_q;

        // Results only update for valid samples so the outputs hold between them.
        out_x_d = out_x_q;
        out_y_d = out_y_q;
        out_m_d = out_m_q;
        if (v3_q) begin
            out_x_d = {sum_c[1], sum_c[0]};
            out_y_d = {diff_c[1], diff_c[0]};
            out_m_d = m3_q;
        end
        out_ovf_d = v3_q & (|ovf_c);
    end

    // Valid bits and outputs are reset; a reset empties the whole pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            v4_q      <= 1'b0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_m_q   <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            v4_q      <= v4_d;
            out_x_q   <= out_x_d;
            out_y_q   <= out_y_d;
            out_m_q   <= out_m_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    // Data path registers load every cycle; validity lives in v1..v4.
    always_ff @(posedge clk) begin
        x1_q <= x1_d;
        y1_q <= y1_d;
        m1_q <= m1_d;
        x2_q <= x2_d;
        m2_q <= m2_d;
        x3_q <= x3_d;
        m3_q <= m3_d;
    end

    assign out_nd  = v4_q;
    assign out_x   = out_x_q;
    assign out_y   = out_y_q;
    assign out_m   = out_m_q;
    assign out_ovf = out_ovf_q;

endmodule

// File: tb/tb_butterfly_tf.sv
// -----------------------------------------------------------------------------
// tb_butterfly_tf
// Scoreboard bench for butterfly_tf. A registered twiddle ROM stands in for
// the lookup. Stimulus pushes expected results (constants or a plain
// arithmetic reference) tagged with their due cycle; a negedge monitor pops
// and compares whenever out_nd is high.
// -----------------------------------------------------------------------------
module tb_butterfly_tf;

    localparam int XW = 12;
    localparam int TW = 12;
    localparam int AW = 4;
    localparam int MW = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_nd = 1'b0;
    logic [AW-1:0]   in_addr = '0;
    logic [2*XW-1:0] in_x = '0;
    logic [2*XW-1:0] in_y = '0;
    logic [MW-1:0]   in_m = '0;
    logic [AW-1:0]   tf_addr;
    logic            tf_addr_nd;
    logic [2*TW-1:0] tf_in = '0;
    logic            out_nd;
    logic [2*XW-1:0] out_x;
    logic [2*XW-1:0] out_y;
    logic [MW-1:0]   out_m;
    logic            out_ovf;

    butterfly_tf dut (
        .clk        (clk),
        .rst        (rst),
        .in_nd      (in_nd),
        .in_addr    (in_addr),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_m       (in_m),
        .tf_addr    (tf_addr),
        .tf_addr_nd (tf_addr_nd),
        .tf_in      (tf_in),
        .out_nd     (out_nd),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_m      (out_m),
        .out_ovf    (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int oxr; int oxi; int oyr; int oyi; int m; int ovf; int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   rom_re[16];
    int   rom_im[16];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   nd_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered twiddle lookup: W_k = exp(-j*2*pi*k/32) in Q10.
    always @(posedge clk) begin
        if (tf_addr_nd)
            tf_in <= {12'(rom_re[tf_addr]), 12'(rom_im[tf_addr])};
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sx(input logic [11:0] v);
        return int'(signed'(v));
    endfunction

    function automatic int clamp(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    // Reference: z = W*y in Q10 with floor, outputs halved with floor, clamped.
    function automatic exp_t model(input int addr, input int xr, input int xi,
                                   input int yr, input int yi, input int m, input int due);
        exp_t e;
        int wr, wi, zr, zi, sr, si, dr, di;
        wr = rom_re[addr];
        wi = rom_im[addr];
        zr = (yr * wr - yi * wi) >>> 10;
        zi = (yr * wi + yi * wr) >>> 10;
        sr = (xr + zr) >>> 1;
        si = (xi + zi) >>> 1;
        dr = (xr - zr) >>> 1;
        di = (xi - zi) >>> 1;
        e.oxr = clamp(sr);
        e.oxi = clamp(si);
        e.oyr = clamp(dr);
        e.oyi = clamp(di);
        e.ovf = (e.oxr != sr || e.oxi != si || e.oyr != dr || e.oyi != di) ? 1 : 0;
        e.m   = m;
        e.cyc = due;
        return e;
    endfunction

    task automatic push_const(input int oxr, input int oxi, input int oyr,
                              input int oyi, input int m, input int ovf);
        exp_t e;
        e.oxr = oxr; e.oxi = oxi; e.oyr = oyr; e.oyi = oyi;
        e.m = m; e.ovf = ovf; e.cyc = cyc + 4;
        sb.push_back(e);
    endtask

    // Called one time unit after a rising edge; occupies exactly one cycle.
    task automatic send(input int addr, input int xr, input int xi,
                        input int yr, input int yi, input int m);
        in_nd   = 1'b1;
        in_addr = addr[AW-1:0];
        in_x    = {xr[11:0], xi[11:0]};
        in_y    = {yr[11:0], yi[11:0]};
        in_m    = m[MW-1:0];
        @(posedge clk);
        #1;
        in_nd = 1'b0;
    endtask

    task automatic send_model(input int addr, input int m);
        int xr, xi, yr, yi;
        xr = int'($urandom_range(4095)) - 2048;
        xi = int'($urandom_range(4095)) - 2048;
        yr = int'($urandom_range(4095)) - 2048;
        yi = int'($urandom_range(4095)) - 2048;
        sb.push_back(model(addr, xr, xi, yr, yi, m, cyc + 4));
        send(addr, xr, xi, yr, yi, m);
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 30 && sb.size() != 0; t++) @(posedge clk);
        #1;
        chk(name, sb.size(), 0);
    endtask

    // Monitor: one line per output transaction.
    always @(negedge clk) begin
        if (out_nd) begin
            nd_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_out_nd", int'(out_nd), 0);
            end else begin
                mon_e = sb.pop_front();
                $display("out cyc=%0d x=(%0d,%0d) y=(%0d,%0d) m=%0d ovf=%0d",
                         cyc, sx(out_x[23:12]), sx(out_x[11:0]),
                         sx(out_y[23:12]), sx(out_y[11:0]), out_m, out_ovf);
                chk("latency_cycle", cyc, mon_e.cyc);
                chk("out_x_re", sx(out_x[23:12]), mon_e.oxr);
                chk("out_x_im", sx(out_x[11:0]), mon_e.oxi);
                chk("out_y_re", sx(out_y[23:12]), mon_e.oyr);
                chk("out_y_im", sx(out_y[11:0]), mon_e.oyi);
                chk("out_m", int'(out_m), mon_e.m);
                chk("out_ovf", int'(out_ovf), mon_e.ovf);
            end
        end else begin
            chk("ovf_idle", int'(out_ovf), 0);
        end
    end

    int nd_before;

    initial begin
        for (int k = 0; k < 16; k++) begin
            real a;
            a = 2.0 * 3.14159265358979 * k / 32.0;
            rom_re[k] = int'(1024.0 * $cos(a));
            rom_im[k] = int'(-1024.0 * $sin(a));
        end

        // Reset held with in_nd high: strobe and outputs stay quiet.
        rst     = 1'b1;
        in_nd   = 1'b1;
        in_addr = 4'd3;
        in_x    = 24'h123456;
        in_y    = 24'h654321;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tf_addr_nd", int'(tf_addr_nd), 0);
            chk("rst_out_nd", int'(out_nd), 0);
            chk("rst_out_x", int'(out_x), 0);
            chk("rst_out_y", int'(out_y), 0);
            chk("rst_out_m", int'(out_m), 0);
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        in_nd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_out_nd", int'(out_nd), 0);
            chk("post_rst_out_x", int'(out_x), 0);
            chk("post_rst_out_y", int'(out_y), 0);
        end
        @(posedge clk);
        #1;

        // Address passes straight through to the lookup.
        in_addr = 4'd5;
        #1;
        chk("tf_addr_comb", int'(tf_addr), 5);
        @(posedge clk);
        #1;

        // Directed cases with hand-computed results.
        push_const(75, 10, 25, -10, 0, 0);
        send(0, 100, 0, 50, 20, 0);
        push_const(0, -100, 0, 100, 1, 0);
        send(8, 0, 0, 200, 0, 1);
        push_const(2047, 1023, -424, 1023, 0, 1);
        send(4, 2047, 2047, 2047, 2047, 0);
        drain("drain_directed");

        // Back-to-back stream over all twiddles, alternating message.
        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) send_model(k, k % 2);
        drain("drain_stream");

        // Random traffic with gaps.
        @(posedge clk);
        #1;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(1) == 1) begin
                send_model(int'($urandom_range(15)), int'($urandom_range(1)));
            end else begin
                @(posedge clk);
                #1;
            end
        end
        drain("drain_random");

        // Reset pulse with three samples in flight.
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) send_model(int'($urandom_range(15)), k % 2);
        nd_before = nd_cnt;
        rst   = 1'b1;
        in_nd = 1'b1;
        @(negedge clk);
        chk("midrst_tf_addr_nd", int'(tf_addr_nd), 0);
        @(posedge clk);
        sb.delete();
        #1;
        rst   = 1'b0;
        in_nd = 1'b0;
        @(posedge clk);
        #1;
        send_model(int'($urandom_range(15)), 1);
        drain("drain_after_reset");
        chk("midrst_out_count", nd_cnt - nd_before, 1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
